// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit completion inputs and common data bus broadcast outputs
interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int XLEN      = 32,
    parameter int PW        = 6
);
    logic [NUM_FU-1:0]                fu_done_i;
    logic [NUM_FU-1:0][XLEN-1:0]      fu_result_i;
    logic [NUM_FU-1:0][PW-1:0]        fu_dest_reg_i;
    logic [NUM_FU-1:0]                fu_dest_reg_sel_i;
    logic [1:0]                       branch_recover_i;
    logic [NUM_FU-1:0]                fu_complete_en_o;
    logic [CDB_WIDTH-1:0]             cdb_valid_o;
    logic [CDB_WIDTH-1:0][PW-1:0]     cdb_tag_o;
    logic [CDB_WIDTH-1:0][XLEN-1:0]   cdb_value_o;
    logic [CDB_WIDTH-1:0]             cdb_wr_en_o;
    logic [31:0]                      completed_cnt_o;

    modport master (
        output fu_done_i, fu_result_i, fu_dest_reg_i, fu_dest_reg_sel_i, branch_recover_i,
        input  fu_complete_en_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_wr_en_o, completed_cnt_o
    );

    modport slave (
        input  fu_done_i, fu_result_i, fu_dest_reg_i, fu_dest_reg_sel_i, branch_recover_i,
        output fu_complete_en_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_wr_en_o, completed_cnt_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin selection of up to CDB_WIDTH finished units per cycle,
// broadcast one cycle later on the CDB; branch recovery squashes grants and broadcasts.
module cdb_arbiter #(
    parameter int NUM_FU      = 4,
    parameter int CDB_WIDTH   = 2,
    parameter int XLEN        = 32,
    parameter int PREG_NUMBER = 64,
    parameter int PW          = $clog2(PREG_NUMBER)
) (
    input logic clk,
    input logic reset,
    cdb_arbiter_if.slave bus
);
    localparam int RW = $clog2(NUM_FU);
    localparam logic DEST_RD = 1'b1;

    logic [RW-1:0]                  rr_ptr;
    logic [CDB_WIDTH-1:0]           slot_valid;
    logic [CDB_WIDTH-1:0][PW-1:0]   slot_tag;
    logic [CDB_WIDTH-1:0][XLEN-1:0] slot_value;
    logic [CDB_WIDTH-1:0]           slot_sel;
    logic [31:0]                    completed_cnt;
    logic [NUM_FU-1:0]              grant;
    logic [CDB_WIDTH-1:0]           slot_hit;
    logic [CDB_WIDTH-1:0][RW-1:0]   slot_fu;
    logic [CDB_WIDTH-1:0]           cdb_valid;
    logic [RW-1:0]                  next_rr;
    logic                           squash;
    logic                           unused_recover_hi;
    int                             idx;
    int                             found;
    int                             last;

    assign squash            = bus.branch_recover_i[0];
    assign unused_recover_hi = bus.branch_recover_i[1];

    // Scan from rr_ptr; the n-th done unit found takes slot n-1, so slots fill without gaps.
    always_comb begin
        grant    = '0;
        slot_hit = '0;
        slot_fu  = '0;
        found    = 0;
        last     = 0;
        idx      = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_FU;
            if (bus.fu_done_i[RW'(idx)] && found < CDB_WIDTH) begin
                grant[RW'(idx)] = 1'b1;
                for (int j = 0; j < CDB_WIDTH; j++) begin
                    if (found == j) begin
                        slot_hit[j] = 1'b1;
                        slot_fu[j]  = RW'(idx);
                    end
                end
                last  = idx;
                found = found + 1;
            end
        end
        next_rr = RW'((last + 1) % NUM_FU);
    end

    assign cdb_valid            = slot_valid & {CDB_WIDTH{!squash}};
    assign bus.fu_complete_en_o = (reset || squash) ? '0 : grant;
    assign bus.cdb_valid_o      = cdb_valid;
    assign bus.cdb_tag_o        = slot_tag;
    assign bus.cdb_value_o      = slot_value;
    assign bus.completed_cnt_o  = completed_cnt;

    always_comb begin
        bus.cdb_wr_en_o = '0;
        for (int j = 0; j < CDB_WIDTH; j++) bus.cdb_wr_en_o[j] = cdb_valid[j] && slot_sel[j] == DEST_RD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            slot_valid    <= '0;
            slot_tag      <= '0;
            slot_value    <= '0;
            slot_sel      <= '0;
            completed_cnt <= '0;
        end else begin
            completed_cnt <= completed_cnt + 32'($countones(cdb_valid));
            rr_ptr        <= squash ? '0 : (found != 0) ? next_rr : rr_ptr;
            for (int j = 0; j < CDB_WIDTH; j++) begin
                slot_valid[j] <= slot_hit[j] && !squash;
                if (slot_hit[j] && !squash) begin
                    slot_tag[j]   <= bus.fu_dest_reg_i[slot_fu[j]];
                    slot_value[j] <= bus.fu_result_i[slot_fu[j]];
                    slot_sel[j]   <= bus.fu_dest_reg_sel_i[slot_fu[j]];
                end
            end
        end
    end
endmodule
